// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: phase encodings, chip codes and access-delay lookup for the ROM reader.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rom_reader_pkg;

   // Phase code doubles as the registered operation output, so values are one-hot (IDLE = 0).
   typedef enum logic [3:0] {
      ST_IDLE      = 4'b0000,
      ST_LOAD_ADDR = 4'b0001,
      ST_WAIT      = 4'b0010,
      ST_READ      = 4'b0100,
      ST_OUTPUT    = 4'b1000
   } state_t;

   // Chip codes: 3601 is the fast part, anything else gets the slow access window.
   localparam int CHIP_3601  = 0;
   localparam int DELAY_3601 = 2;
   localparam int DELAY_SLOW = 4;

   // Cycles to wait between the last address bit and the first data bit.
   function automatic int access_delay(input int chip);
      return (chip == CHIP_3601) ? DELAY_3601 : DELAY_SLOW;
   endfunction

   // Largest of three phase lengths, used to size the shared phase counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rom_reader_shifter.sv
// rom_reader_shifter: generic parallel-load / serial shift register, MSB out, serial in at LSB.
// Latency: one cycle per load or shift; o_par_nxt shows the value the next edge will store.
// Backpressure: none; load has priority over shift, register holds when neither is asserted.
module rom_reader_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_par_dat,
   input  logic             i_shift,
   input  logic             i_ser_dat,
   output logic [WIDTH-1:0] o_par_nxt,
   output logic             o_ser_dat
);

   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_nxt;

   // A one-bit register has no upper slice to keep, so it simply takes the serial bit.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_shifted = i_ser_dat;
      end else begin : g_wn
         assign w_shifted = {r_sr[WIDTH-2:0], i_ser_dat};
      end
   endgenerate

   // Next-value select: parallel load wins over a shift.
   always_comb begin
      w_nxt = r_sr;
      if (i_load) begin
         w_nxt = i_par_dat;
      end else if (i_shift) begin
         w_nxt = w_shifted;
      end
   end

   // Shift register storage, cleared on reset.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sr <= '0;
      end else begin
         r_sr <= w_nxt;
      end
   end

   assign o_par_nxt = w_nxt;
   assign o_ser_dat = r_sr[WIDTH-1];

endmodule

// File: rtl/rom_reader.sv
// rom_reader: steps a ROM address on button edges, shifts it out, waits, shifts data in, replays it.
// Latency: ADDRESS_WIDTH + access delay + 2*DATA_WIDTH cycles from LOAD_ADDR entry to IDLE (18 by default).
// Backpressure: none; request edges seen outside IDLE are dropped, never queued.
module rom_reader
   import rom_reader_pkg::*;
#(
   parameter int DATA_WIDTH    = 4,
   parameter int ADDRESS_WIDTH = 8,
   parameter int SELECTED_CHIP = CHIP_3601
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       increment_address,
   input  logic       decrement_address,
   input  logic       data_line_in,
   output logic [3:0] operation,
   output logic       address_line,
   output logic       data_line
);

   localparam int WAIT_CYCLES = access_delay(SELECTED_CHIP);
   localparam int CNT_W       = $clog2(max3(ADDRESS_WIDTH, DATA_WIDTH, WAIT_CYCLES) + 1);

   localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDRESS_WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);

   state_t                   r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic                     r_inc_q;
   logic                     r_dec_q;

   logic                     w_inc_rise;
   logic                     w_dec_rise;
   logic                     w_step;
   logic [ADDRESS_WIDTH-1:0] w_addr_next;
   logic                     w_read_last;
   logic [DATA_WIDTH-1:0]    w_captured;
   logic [ADDRESS_WIDTH-1:0] w_unused_addr_nxt;
   logic                     w_unused_data_msb;
   logic [DATA_WIDTH-1:0]    w_unused_out_nxt;

   // A step needs exactly one fresh rising edge while idle; simultaneous edges cancel out.
   assign w_inc_rise  = increment_address & ~r_inc_q;
   assign w_dec_rise  = decrement_address & ~r_dec_q;
   assign w_step      = (r_state == ST_IDLE) & (w_inc_rise ^ w_dec_rise);
   assign w_addr_next = w_inc_rise ? (r_addr + ADDRESS_WIDTH'(1)) : (r_addr - ADDRESS_WIDTH'(1));
   assign w_read_last = (r_state == ST_READ) && (r_cnt == LAST_DATA);

   // Phase sequencer, address counter and request edge detectors.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_LOAD_ADDR;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_inc_q <= 1'b0;
         r_dec_q <= 1'b0;
      end else begin
         r_inc_q <= increment_address;
         r_dec_q <= decrement_address;
         case (r_state)
            ST_IDLE: begin
               if (w_step) begin
                  r_addr  <= w_addr_next;
                  r_cnt   <= '0;
                  r_state <= ST_LOAD_ADDR;
               end
            end
            ST_LOAD_ADDR: begin
               if (r_cnt == LAST_ADDR) begin
                  r_cnt   <= '0;
                  r_state <= ST_WAIT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (r_cnt == LAST_WAIT) begin
                  r_cnt   <= '0;
                  r_state <= ST_READ;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_READ: begin
               if (r_cnt == LAST_DATA) begin
                  r_cnt   <= '0;
                  r_state <= ST_OUTPUT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_OUTPUT: begin
               if (r_cnt == LAST_DATA) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign operation = r_state;

   // Address out: loaded with the new address on the step edge so its MSB is on the line in the
   // first LOAD_ADDR cycle; zeros shift in behind, so the line idles low once all bits are out.
   // After reset the register is zero, which is exactly address 0 ready to send.
   rom_reader_shifter #(
      .WIDTH(ADDRESS_WIDTH)
   ) u_addr_out (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_load    (w_step),
      .i_par_dat (w_addr_next),
      .i_shift   (r_state == ST_LOAD_ADDR),
      .i_ser_dat (1'b0),
      .o_par_nxt (w_unused_addr_nxt),
      .o_ser_dat (address_line)
   );

   // Data in: the captured word, holding its value until the next READ phase.
   rom_reader_shifter #(
      .WIDTH(DATA_WIDTH)
   ) u_data_in (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_load    (1'b0),
      .i_par_dat ({DATA_WIDTH{1'b0}}),
      .i_shift   (r_state == ST_READ),
      .i_ser_dat (data_line_in),
      .o_par_nxt (w_captured),
      .o_ser_dat (w_unused_data_msb)
   );

   // Data out: takes the word including the bit captured on the final READ edge, then drains
   // MSB first with zero fill so the line is low outside OUTPUT.
   rom_reader_shifter #(
      .WIDTH(DATA_WIDTH)
   ) u_data_out (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_load    (w_read_last),
      .i_par_dat (w_captured),
      .i_shift   (r_state == ST_OUTPUT),
      .i_ser_dat (1'b0),
      .o_par_nxt (w_unused_out_nxt),
      .o_ser_dat (data_line)
   );

endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: scoreboard bench for rom_reader at default parameters (3601, 8-bit address, 4-bit data).
// Expected addresses/words are queued when a read is provoked and popped as the serial lines complete.
// Bounded waits; every comparison goes through chk.
module tb_rom_reader;

   localparam int AW = 8;
   localparam int DW = 4;

   localparam logic [3:0] OP_IDLE = 4'b0000;
   localparam logic [3:0] OP_LOAD = 4'b0001;
   localparam logic [3:0] OP_WAIT = 4'b0010;
   localparam logic [3:0] OP_READ = 4'b0100;
   localparam logic [3:0] OP_OUT  = 4'b1000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       increment_address = 1'b0;
   logic       decrement_address = 1'b0;
   logic       data_line_in = 1'b0;
   logic [3:0] operation;
   logic       address_line;
   logic       data_line;

   int n_cmp = 0;
   int n_err = 0;

   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] exp_data_q[$];
   logic [AW-1:0] m_addr;
   logic [DW-1:0] rd_word;

   rom_reader #(
      .DATA_WIDTH   (DW),
      .ADDRESS_WIDTH(AW),
      .SELECTED_CHIP(0)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .increment_address(increment_address),
      .decrement_address(decrement_address),
      .data_line_in     (data_line_in),
      .operation        (operation),
      .address_line     (address_line),
      .data_line        (data_line)
   );

   always #100 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic expect_read(input logic [AW-1:0] a);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(rd_word);
   endtask

   task automatic wait_op(input logic [3:0] st, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (operation !== st && n < 200);
      chk(tag, operation, st);
   endtask

   task automatic pulse(input logic inc, input logic dec);
      increment_address = inc;
      decrement_address = dec;
      @(negedge clk);
      increment_address = 1'b0;
      decrement_address = 1'b0;
   endtask

   // One address step with the read it triggers, run to completion.
   task automatic step(input logic inc);
      m_addr = inc ? m_addr + 8'd1 : m_addr - 8'd1;
      expect_read(m_addr);
      pulse(inc, ~inc);
      wait_op(OP_IDLE, "step_idle");
   endtask

   // ROM model: presents rd_word MSB first during READ, noise otherwise.
   initial begin : drv
      int rk;
      rk = 0;
      forever begin
         @(negedge clk);
         if (reset_n && operation == OP_READ) begin
            data_line_in = rd_word[DW-1-rk];
            rk++;
         end else begin
            rk = 0;
            data_line_in = 1'($urandom_range(0, 1));
         end
      end
   end

   // Serial monitor: assemble address and data words and check them against the scoreboard.
   logic [AW-1:0] mon_abits;
   logic [DW-1:0] mon_dbits;
   int            mon_acnt = 0;
   int            mon_dcnt = 0;

   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mon_acnt = 0;
         mon_dcnt = 0;
      end else begin
         if (operation == OP_LOAD) begin
            mon_abits = {mon_abits[AW-2:0], address_line};
            mon_acnt++;
            if (mon_acnt == AW) begin
               mon_acnt = 0;
               chk("addr_expected", exp_addr_q.size() != 0, 1'b1);
               if (exp_addr_q.size() != 0) chk("addr_serial", mon_abits, exp_addr_q.pop_front());
            end
         end else begin
            chk("addr_quiet", address_line, 1'b0);
         end
         if (operation == OP_OUT) begin
            mon_dbits = {mon_dbits[DW-2:0], data_line};
            mon_dcnt++;
            if (mon_dcnt == DW) begin
               mon_dcnt = 0;
               chk("data_expected", exp_data_q.size() != 0, 1'b1);
               if (exp_data_q.size() != 0) chk("data_serial", mon_dbits, exp_data_q.pop_front());
            end
         end else begin
            chk("data_quiet", data_line, 1'b0);
         end
      end
   end

   initial begin
      logic [3:0] e;
      m_addr  = '0;
      rd_word = 4'b1011;

      // Reset state
      @(negedge clk);
      chk("rst_operation", operation, OP_LOAD);
      chk("rst_address_line", address_line, 1'b0);
      chk("rst_data_line", data_line, 1'b0);

      // Automatic read of address 0 after release, phase by phase
      expect_read(8'h00);
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i < 8) e = OP_LOAD;
         else if (i < 10) e = OP_WAIT;
         else if (i < 14) e = OP_READ;
         else e = OP_OUT;
         chk("phase_seq", operation, e);
      end
      @(negedge clk);
      chk("phase_seq_idle", operation, OP_IDLE);

      // Wrap 0x00 -> 0xFF -> 0x00
      rd_word = 4'b0110;
      step(1'b0);
      rd_word = 4'b1001;
      step(1'b1);

      // Both requests rising together: nothing happens
      increment_address = 1'b1;
      decrement_address = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("both_ignored", operation, OP_IDLE);
      end
      increment_address = 1'b0;
      decrement_address = 1'b0;
      @(negedge clk);

      // Held increment gives exactly one step (0x01)
      rd_word = 4'b0011;
      m_addr  = m_addr + 8'd1;
      expect_read(m_addr);
      increment_address = 1'b1;
      repeat (40) @(negedge clk);
      chk("hold_one_step", operation, OP_IDLE);
      increment_address = 1'b0;
      @(negedge clk);

      // Step to 0x02, then a request during READ must be dropped
      rd_word = 4'b1100;
      m_addr  = m_addr + 8'd1;
      expect_read(m_addr);
      pulse(1'b1, 1'b0);
      wait_op(OP_READ, "reach_read");
      pulse(1'b1, 1'b0);
      wait_op(OP_IDLE, "idle_after_read");
      repeat (3) begin
         @(negedge clk);
         chk("no_queued", operation, OP_IDLE);
      end

      // Address still 0x02: decrement reads 0x01
      rd_word = 4'b0101;
      step(1'b0);

      // Reset in the middle of OUTPUT aborts at once, then address 0 is read again
      rd_word = 4'b1111;
      m_addr  = m_addr + 8'd1;
      expect_read(m_addr);
      pulse(1'b1, 1'b0);
      wait_op(OP_OUT, "reach_output");
      @(negedge clk);
      chk("pre_reset_data", data_line, 1'b1);
      #50 reset_n = 1'b0;
      exp_addr_q.delete();
      exp_data_q.delete();
      m_addr  = '0;
      rd_word = 4'b1000;
      expect_read(8'h00);
      #1;
      chk("async_rst_operation", operation, OP_LOAD);
      chk("async_rst_address_line", address_line, 1'b0);
      chk("async_rst_data_line", data_line, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      wait_op(OP_IDLE, "restart_idle");
      repeat (2) @(negedge clk);

      chk("addr_q_drained", exp_addr_q.size(), 0);
      chk("data_q_drained", exp_data_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
